// File: rtl/tlb_miss_queue_pkg.sv
// Shared types and constants for the TLB miss queue: entry layout, attribute
// bit positions and the 16 KB even/odd page key used for duplicate suppression.
package tlb_miss_queue_pkg;

  localparam int MAX_ADDR_W   = 64;
  localparam int ATTR_W       = 4;
  localparam int ATTR_VM      = 3;
  localparam int PERMREQ_CODE = 0;
  localparam int PERMREQ_W    = 1;
  localparam int PAGE_LO      = 14;
  localparam int KEY_W        = MAX_ADDR_W - PAGE_LO + 1;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [ATTR_W-1:0]     attr;
    logic                  inv;
    logic                  code;
  } miss_entry_t;

  // Key of the even/odd page pair the walker fills, qualified by the VM bit.
  function automatic logic [KEY_W-1:0] page_key(input miss_entry_t e);
    return {e.addr[MAX_ADDR_W-1:PAGE_LO], e.attr[ATTR_VM]};
  endfunction

endpackage

// File: rtl/tlb_miss_queue_fifo.sv
// Circular buffer of data misses with flush, occupancy count and a per-entry
// page-key compare used to drop duplicate misses on arrival.
module tlbmq_fifo
  import tlb_miss_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  miss_entry_t       push_data,
  input  logic              pop,
  output miss_entry_t       head,
  output logic [PTR_W:0]    count,
  input  logic [KEY_W-1:0]  cmp_key,
  input  logic              cmp_code,
  output logic [DEPTH-1:0]  hit
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  miss_entry_t       mem [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    cnt;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && (cnt != FULL_CNT);
  assign do_pop  = pop && (cnt != '0);
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      vld    <= '0;
    end else begin
      // rd_ptr and wr_ptr only coincide when empty or full, so the two
      // valid-bit updates below never target the same slot.
      if (do_push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      cnt <= cnt + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign hit[i] = vld[i] && (page_key(mem[i]) == cmp_key) && (mem[i].code == cmp_code);
  end

endmodule

// File: rtl/tlb_miss_queue.sv
// Collects data and code TLB misses, suppresses duplicates of pages already
// pending, and hands them one at a time to the page walker.
module tlb_miss_queue
  import tlb_miss_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 except,
  input  logic                 dmiss_en,
  input  logic [ADDR_W-1:0]    dmiss_addr,
  input  logic [ATTR_W-1:0]    dmiss_attr,
  input  logic                 dmiss_inv,
  output logic                 dmiss_can,
  input  logic                 cmiss_en,
  input  logic [ADDR_W-1:0]    cmiss_addr,
  input  logic [ATTR_W-1:0]    cmiss_attr,
  output logic                 cmiss_can,
  output logic                 walk_en,
  input  logic                 walk_can,
  output logic [ADDR_W-1:0]    walk_addr,
  output logic [ATTR_W-1:0]    walk_attr,
  output logic                 walk_inv,
  output logic [PERMREQ_W-1:0] walk_permReq,
  input  logic                 walk_done,
  output logic                 busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // Walker handshake: walk_en with walk_* is held stable until walk_can is
  // seen high; that cycle transfers the entry and walk_en drops next cycle.

  miss_entry_t      d_in, c_in, fifo_head, cand;
  miss_entry_t      code_ent, walk_ent, infl_ent;
  logic             code_vld, walk_en_q, infl_vld;
  logic [PTR_W:0]   fifo_cnt;
  logic [DEPTH-1:0] fifo_hit;
  logic [KEY_W-1:0] d_key, c_key, infl_key, code_key;
  logic             d_acc, c_acc, d_dup, c_dup, d_push, c_load;
  logic             walk_pop, issue_ok, cand_vld, issue;

  always_comb begin
    d_in      = '0;
    d_in.addr = MAX_ADDR_W'(dmiss_addr);
    d_in.attr = dmiss_attr;
    d_in.inv  = dmiss_inv;
    d_in.code = 1'b0;
    c_in      = '0;
    c_in.addr = MAX_ADDR_W'(cmiss_addr);
    c_in.attr = cmiss_attr;
    c_in.inv  = 1'b0;
    c_in.code = 1'b1;
  end

  assign d_key    = page_key(d_in);
  assign c_key    = page_key(c_in);
  assign infl_key = page_key(infl_ent);
  assign code_key = page_key(code_ent);

  assign dmiss_can = (fifo_cnt != FULL_CNT);
  assign cmiss_can = !code_vld;

  assign d_acc = dmiss_en && dmiss_can && !except;
  assign c_acc = cmiss_en && cmiss_can && !except;

  // FIFO entries are all data misses, so a code miss can only repeat the
  // in-flight walk; invalidates are always kept.
  assign d_dup = !d_in.inv && (
                   (infl_vld && infl_ent.code == d_in.code && infl_key == d_key) ||
                   (|fifo_hit) ||
                   (code_vld && code_ent.code == d_in.code && code_key == d_key) ||
                   (c_acc && c_in.code == d_in.code && c_key == d_key));
  assign c_dup = !c_in.inv && infl_vld && infl_ent.code && (infl_key == c_key);

  assign d_push = d_acc && !d_dup;
  assign c_load = c_acc && !c_dup;

  assign walk_pop = walk_en_q && walk_can;
  assign issue_ok = !walk_en_q && (!infl_vld || walk_done) && !except;

  // Incoming misses bypass straight to the walker when their slot is empty,
  // while still being stored so they leave on acceptance like any other.
  always_comb begin
    cand     = code_ent;
    cand_vld = 1'b1;
    if (code_vld) begin
      cand = code_ent;
    end else if (c_load) begin
      cand = c_in;
    end else if (fifo_cnt != '0) begin
      cand = fifo_head;
    end else if (d_push) begin
      cand = d_in;
    end else begin
      cand_vld = 1'b0;
    end
  end

  assign issue = issue_ok && cand_vld;

  tlbmq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (except),
    .push      (d_push),
    .push_data (d_in),
    .pop       (walk_pop && !walk_ent.code),
    .head      (fifo_head),
    .count     (fifo_cnt),
    .cmp_key   (d_key),
    .cmp_code  (d_in.code),
    .hit       (fifo_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      infl_vld  <= 1'b0;
      infl_ent  <= '0;
      walk_en_q <= 1'b0;
      walk_ent  <= '0;
      code_vld  <= 1'b0;
      code_ent  <= '0;
    end else begin
      if (walk_pop) begin
        infl_vld <= 1'b1;
        infl_ent <= walk_ent;
      end else if (walk_done) begin
        infl_vld <= 1'b0;
      end

      if (issue) begin
        walk_en_q <= 1'b1;
        walk_ent  <= cand;
      end else if (walk_pop || except) begin
        walk_en_q <= 1'b0;
      end

      if (except) begin
        code_vld <= 1'b0;
      end else if (walk_pop && walk_ent.code) begin
        code_vld <= 1'b0;
      end else if (c_load) begin
        code_vld <= 1'b1;
        code_ent <= c_in;
      end
    end
  end

  always_comb begin
    walk_permReq               = '0;
    walk_permReq[PERMREQ_CODE] = walk_ent.code;
  end

  assign walk_en   = walk_en_q;
  assign walk_addr = walk_ent.addr[ADDR_W-1:0];
  assign walk_attr = walk_ent.attr;
  assign walk_inv  = walk_ent.inv;
  assign busy      = infl_vld || walk_en_q || code_vld || (fifo_cnt != '0);

endmodule
